// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and decode helpers.
package vga_pkg;

  // 640x480@60 Hz from a 100 MHz system clock.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CLK_DIV  = 4;

  // Largest total the 10-bit coordinate outputs can represent.
  localparam int unsigned MAX_TOTAL = 1024;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Horizontal total in pixels.
  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Vertical total in lines.
  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // True when v lies in [start, start+len).
  function automatic logic in_window(input int unsigned v, input int unsigned start,
                                     input int unsigned len);
    return (v >= start) && (v < start + len);
  endfunction

  // Pin level for a sync pulse given its asserted polarity.
  function automatic logic sync_level(input logic asserted, input bit pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-N counter with enable and a wrap strobe for chaining.
module mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Wrap fires in the enabled cycle that returns the count to zero.
  always_comb begin
    wrap    = en && (count_q == WIDTH'(MODULUS - 1));
    count_d = count_q;
    if (wrap)    count_d = '0;
    else if (en) count_d = count_q + WIDTH'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate tick, x/y counters and registered sync/blank decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter bit          SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       blanking,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             div_wrap;
  logic [9:0]       x_q, y_q;
  logic [9:0]       x_d, y_d;
  logic             x_wrap, y_wrap;

  logic pix_tick_q, pix_tick_d;
  logic blank_q, blank_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic frame_q, frame_d;

  mod_counter #(.WIDTH(DIV_W), .MODULUS(CLK_DIV)) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (div_q),
    .wrap  (div_wrap)
  );

  // x advances on the registered tick so that no pixel step happens while
  // pix_tick is held low by reset, even with CLK_DIV=1.
  mod_counter #(.WIDTH(10), .MODULUS(H_TOTAL)) u_x (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_tick_q),
    .count (x_q),
    .wrap  (x_wrap)
  );

  mod_counter #(.WIDTH(10), .MODULUS(V_TOTAL)) u_y (
    .clk   (clk),
    .rst   (rst),
    .en    (x_wrap),
    .count (y_q),
    .wrap  (y_wrap)
  );

  // Mirror the counters' next state so the decode lands in the same cycle as x/y.
  always_comb begin
    div_d = div_wrap ? '0 : div_q + DIV_W'(1);
    x_d   = x_wrap ? '0 : (pix_tick_q ? x_q + 10'd1 : x_q);
    y_d   = y_wrap ? '0 : (x_wrap ? y_q + 10'd1 : y_q);

    pix_tick_d = (div_d == DIV_W'(CLK_DIV - 1));
    blank_d    = (32'(x_d) >= H_ACTIVE) || (32'(y_d) >= V_ACTIVE);
    hsync_d    = sync_level(in_window(32'(x_d), H_ACTIVE + H_FP, H_SYNC), SYNC_POL);
    vsync_d    = sync_level(in_window(32'(y_d), V_ACTIVE + V_FP, V_SYNC), SYNC_POL);
    frame_d    = y_wrap;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_tick_q <= 1'b0;
      blank_q    <= 1'b0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      frame_q    <= 1'b0;
    end else begin
      pix_tick_q <= pix_tick_d;
      blank_q    <= blank_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      frame_q    <= frame_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign blanking    = blank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing plus two tiny-raster instances.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       a_tick, a_blank, a_hs, a_vs, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_blank, b_hs, b_vs, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_tick, c_blank, c_hs, c_vs, c_fs;
  logic [9:0] c_x, c_y;

  // Default 640x480@60, CLK_DIV=4, active-low syncs.
  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_tick(a_tick), .x(a_x), .y(a_y),
    .blanking(a_blank), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
  );

  // 8x6 raster, CLK_DIV=1, active-low syncs.
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_tick(b_tick), .x(b_x), .y(b_y),
    .blanking(b_blank), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
  );

  // 8x6 raster, CLK_DIV=2, active-high syncs.
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(2), .SYNC_POL(1'b1)
  ) dut_c (
    .clk(clk), .rst(rst), .pix_tick(c_tick), .x(c_x), .y(c_y),
    .blanking(c_blank), .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs of the 8x6 raster at pixel index p (p counts ticks since reset).
  task automatic chk_small(input string tag, input bit pol, input int p,
                           input bit tick_e, input bit fs_e,
                           input logic tick_o, input logic [9:0] x_o, input logic [9:0] y_o,
                           input logic bl_o, input logic hs_o, input logic vs_o,
                           input logic fs_o);
    int  ex, ey;
    bit  hact, vact;
    ex   = p % 8;
    ey   = (p / 8) % 6;
    hact = (ex >= 5) && (ex < 7);
    vact = (ey == 4);
    chk({tag, ".tick"},  tick_o, tick_e);
    chk({tag, ".x"},     x_o, ex);
    chk({tag, ".y"},     y_o, ey);
    chk({tag, ".blank"}, bl_o, (ex >= 4) || (ey >= 3));
    chk({tag, ".hsync"}, hs_o, pol ? hact : !hact);
    chk({tag, ".vsync"}, vs_o, pol ? vact : !vact);
    chk({tag, ".fs"},    fs_o, fs_e);
  endtask

  int n, last, tick_idx, cyc;
  int pb, pc;
  int fall_cyc, rise_cyc;
  bit seen_fall, seen_rise, seen_blank, seen_wrap;
  logic [9:0] prev_x, prev_y;
  logic       prev_hs, prev_blank;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Tiny rasters: cycle-by-cycle through a full frame and the simultaneous x/y wrap.
    for (int k = 0; k < 110; k++) begin
      pb = (k >= 1) ? k - 1 : 0;
      pc = k / 2;
      chk_small("b", 1'b0, pb, k >= 1, (k >= 2) && (pb % 48 == 0),
                b_tick, b_x, b_y, b_blank, b_hs, b_vs, b_fs);
      chk_small("c", 1'b1, pc, (k % 2) == 1, (k >= 2) && (k % 2 == 0) && (pc % 48 == 0),
                c_tick, c_x, c_y, c_blank, c_hs, c_vs, c_fs);
      @(negedge clk);
    end

    // Bring the default raster to x=300 and reset it mid-line.
    n = 0;
    while (a_x != 10'd300 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("a.reach_x300", a_x, 300);
    rst = 1'b1;
    @(negedge clk);
    chk("a.rst.x", a_x, 0);
    chk("a.rst.y", a_y, 0);
    chk("a.rst.blank", a_blank, 0);
    chk("a.rst.hsync", a_hs, 1);
    chk("a.rst.vsync", a_vs, 1);
    chk("a.rst.fs", a_fs, 0);
    chk("a.rst.tick", a_tick, 0);
    chk("c.rst.hsync", c_hs, 0);
    chk("c.rst.vsync", c_vs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First tick lands in the CLK_DIV-th cycle after release.
    n = 1;
    while (!a_tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a.first_tick", n, 4);
    chk("a.first_tick.x", a_x, 0);

    // Tick spacing and x stepping over 40 clocks.
    last     = n;
    tick_idx = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (a_tick) begin
        tick_idx++;
        chk("a.tick_gap", n - last, 4);
        chk("a.tick_x", a_x, tick_idx);
        last = n;
      end
    end
    chk("a.tick_count", tick_idx, 10);

    // One full line: sync/blank decode and the x wrap into the next line.
    seen_fall  = 1'b0;
    seen_rise  = 1'b0;
    seen_blank = 1'b0;
    seen_wrap  = 1'b0;
    fall_cyc   = 0;
    rise_cyc   = 0;
    cyc        = 0;
    prev_x     = a_x;
    prev_y     = a_y;
    prev_hs    = a_hs;
    prev_blank = a_blank;
    while (!seen_wrap && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      chk("a.line.blank", a_blank, (a_x >= 10'd640) ? 1 : 0);
      chk("a.line.hsync", a_hs, (a_x >= 10'd656 && a_x < 10'd752) ? 0 : 1);
      chk("a.line.vsync", a_vs, 1);
      if (prev_hs && !a_hs) begin
        seen_fall = 1'b1;
        fall_cyc  = cyc;
        chk("a.hsync_fall_x", a_x, 656);
      end
      if (!prev_hs && a_hs) begin
        seen_rise = 1'b1;
        rise_cyc  = cyc;
        chk("a.hsync_rise_x", a_x, 752);
        chk("a.hsync_low_clks", rise_cyc - fall_cyc, 384);
      end
      if (!prev_blank && a_blank) begin
        seen_blank = 1'b1;
        chk("a.blank_rise_x", a_x, 640);
      end
      if (a_x != prev_x && a_x == 10'd0) begin
        seen_wrap = 1'b1;
        chk("a.wrap_from_x", prev_x, 799);
        chk("a.wrap_y", a_y, prev_y + 10'd1);
        chk("a.wrap_fs", a_fs, 0);
      end
      prev_x     = a_x;
      prev_y     = a_y;
      prev_hs    = a_hs;
      prev_blank = a_blank;
    end
    chk("a.seen_hsync_fall", seen_fall, 1);
    chk("a.seen_hsync_rise", seen_rise, 1);
    chk("a.seen_blank_rise", seen_blank, 1);
    chk("a.seen_line_wrap", seen_wrap, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
